// File: rtl/ctrl_pipe_regs.sv
// E/M/W control-word pipeline with per-stage stall/flush/bubble handling and the divide stall sequencer.
// Optional macro CTRL_PIPE_PC_EN adds a PC that travels alongside the control bundle.
module ctrl_pipe_regs #(
    parameter int CTRL_W  = 18,
    parameter int DIV_LAT = 32     // legal range 1..255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic              validD,
    input  logic              flushE,
    input  logic              flush_all,
    input  logic              mem_stall,
    input  logic              div_startE,
`ifdef CTRL_PIPE_PC_EN
    input  logic [31:0]       pcD,
    output logic [31:0]       pcE,
    output logic [31:0]       pcM,
    output logic [31:0]       pcW,
`endif
    output logic [CTRL_W-1:0] ctrlE,
    output logic [CTRL_W-1:0] ctrlM,
    output logic [CTRL_W-1:0] ctrlW,
    output logic              validE,
    output logic              validM,
    output logic              validW,
    output logic              stallD,
    output logic              div_busy,
    output logic              div_done
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } divState_e;

    localparam logic [7:0] DIV_RELOAD = 8'(DIV_LAT - 1);

    divState_e  divState, divStateNext;
    logic [7:0] divCnt, divCntNext;
    logic       divStart;
    logic       stallE;
    logic       stallM;

    assign stallE = div_busy | mem_stall;
    assign stallM = mem_stall;
    assign stallD = div_busy | mem_stall;

    // ---------------- divide sequencer ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divState <= DIV_IDLE;
            divCnt   <= 8'd0;
        end else begin
            divState <= divStateNext;
            divCnt   <= divCntNext;
        end
    end

    always_comb begin
        divStateNext = divState;
        divCntNext   = divCnt;
        divStart     = 1'b0;
        unique case (divState)
            DIV_IDLE: begin
                // A bubble in E never starts the divider, even if the decode bit is stale.
                divStart = div_startE & validE & ~flush_all;
                if (divStart) begin
                    divStateNext = DIV_BUSY;
                    divCntNext   = DIV_RELOAD;
                end
            end
            DIV_BUSY: begin
                if (flush_all) begin
                    divStateNext = DIV_IDLE;
                    divCntNext   = 8'd0;
                end else if (divCnt == 8'd0) begin
                    divStateNext = DIV_DONE;
                end else begin
                    divCntNext = divCnt - 8'd1;
                end
            end
            DIV_DONE: begin
                // Leave only when E actually advances; an exception also releases it.
                if (!mem_stall || flush_all) begin
                    divStateNext = DIV_IDLE;
                end
            end
            default: begin
                divStateNext = DIV_IDLE;
                divCntNext   = 8'd0;
            end
        endcase
    end

    assign div_busy = divStart | (divState == DIV_BUSY);
    assign div_done = (divState == DIV_DONE);

    // ---------------- E stage ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlE  <= '0;
            validE <= 1'b0;
        end else if (flush_all) begin
            ctrlE  <= '0;
            validE <= 1'b0;
        end else if (stallE) begin
            ctrlE  <= ctrlE;
            validE <= validE;
        end else if (flushE) begin
            ctrlE  <= '0;
            validE <= 1'b0;
        end else begin
            ctrlE  <= ctrlD;
            validE <= validD;
        end
    end

    // ---------------- M stage ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlM  <= '0;
            validM <= 1'b0;
        end else if (flush_all) begin
            ctrlM  <= '0;
            validM <= 1'b0;
        end else if (stallM) begin
            ctrlM  <= ctrlM;
            validM <= validM;
        end else if (stallE) begin
            ctrlM  <= '0;
            validM <= 1'b0;
        end else begin
            ctrlM  <= ctrlE;
            validM <= validE;
        end
    end

    // ---------------- W stage (never stalls) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlW  <= '0;
            validW <= 1'b0;
        end else if (flush_all || stallM) begin
            ctrlW  <= '0;
            validW <= 1'b0;
        end else begin
            ctrlW  <= ctrlM;
            validW <= validM;
        end
    end

`ifdef CTRL_PIPE_PC_EN
    // PCs mirror the control-bundle rules exactly so W always carries the EPC of its instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcE <= 32'h0;
            pcM <= 32'h0;
            pcW <= 32'h0;
        end else if (flush_all) begin
            pcE <= 32'h0;
            pcM <= 32'h0;
            pcW <= 32'h0;
        end else begin
            if (stallE)      pcE <= pcE;
            else if (flushE) pcE <= 32'h0;
            else             pcE <= pcD;

            if (stallM)      pcM <= pcM;
            else if (stallE) pcM <= 32'h0;
            else             pcM <= pcE;

            if (stallM)      pcW <= 32'h0;
            else             pcW <= pcM;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs with DIV_LAT=4: reset, flow, mem stall, divide, abort, stalled DONE.
module tb_ctrl_pipe_regs;
    localparam int CW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] ctrlD;
    logic          validD, flushE, flush_all, mem_stall, div_startE;
    logic [CW-1:0] ctrlE, ctrlM, ctrlW;
    logic          validE, validM, validW, stallD, div_busy, div_done;
`ifdef CTRL_PIPE_PC_EN
    logic [31:0]   pcD, pcE, pcM, pcW;
`endif

    int checkCount = 0;
    int errCount   = 0;

    always #5 clk = ~clk;

    ctrl_pipe_regs #(.CTRL_W(CW), .DIV_LAT(4)) dut (
        .clk(clk), .rst(rst), .ctrlD(ctrlD), .validD(validD), .flushE(flushE),
        .flush_all(flush_all), .mem_stall(mem_stall), .div_startE(div_startE),
`ifdef CTRL_PIPE_PC_EN
        .pcD(pcD), .pcE(pcE), .pcM(pcM), .pcW(pcW),
`endif
        .ctrlE(ctrlE), .ctrlM(ctrlM), .ctrlW(ctrlW),
        .validE(validE), .validM(validM), .validW(validW),
        .stallD(stallD), .div_busy(div_busy), .div_done(div_done)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkStages(input string tag, input logic [CW-1:0] e, input logic ve,
                               input logic [CW-1:0] m, input logic vm,
                               input logic [CW-1:0] w, input logic vw);
        checkVal({tag, " ctrlE"}, 32'(ctrlE), 32'(e));
        checkVal({tag, " validE"}, 32'(validE), 32'(ve));
        checkVal({tag, " ctrlM"}, 32'(ctrlM), 32'(m));
        checkVal({tag, " validM"}, 32'(validM), 32'(vm));
        checkVal({tag, " ctrlW"}, 32'(ctrlW), 32'(w));
        checkVal({tag, " validW"}, 32'(validW), 32'(vw));
    endtask

    task automatic setD(input logic [CW-1:0] c, input logic v);
        ctrlD  = c;
        validD = v;
`ifdef CTRL_PIPE_PC_EN
        pcD = {14'h0, c};
`endif
    endtask

    initial begin
        rst = 1'b0;
        setD('0, 1'b0);
        flushE = 0; flush_all = 0; mem_stall = 0; div_startE = 0;
        #2;
        checkStages("reset0", '0, 0, '0, 0, '0, 0);
        checkVal("reset0 div_busy", 32'(div_busy), 0);
        checkVal("reset0 div_done", 32'(div_done), 0);
        #6 rst = 1'b1;
        tick();
        checkStages("idle", '0, 0, '0, 0, '0, 0);

        // ---- plain flow: 1 cycle per stage ----
        setD(18'h000A5, 1);
        tick();
        checkStages("flow n+1", 18'h000A5, 1, '0, 0, '0, 0);
        setD('0, 0);
        tick();
        checkStages("flow n+2", '0, 0, 18'h000A5, 1, '0, 0);
        tick();
        checkStages("flow n+3", '0, 0, '0, 0, 18'h000A5, 1);
        tick();
        checkVal("flow drained ctrlW", 32'(ctrlW), 0);

        // ---- flushE inserts a bubble into E ----
        setD(18'h00055, 1);
        flushE = 1;
        tick();
        flushE = 0;
        checkVal("flushE ctrlE", 32'(ctrlE), 0);
        checkVal("flushE validE", 32'(validE), 0);

        // ---- mem_stall for 3 cycles with E=11, M=22, W=44 ----
        setD(18'h00044, 1); tick();
        setD(18'h00022, 1); tick();
        setD(18'h00011, 1); tick();
        checkStages("pre-stall", 18'h11, 1, 18'h22, 1, 18'h44, 1);
        setD(18'h00033, 1);
        mem_stall = 1;
        #1 checkVal("mem_stall stallD", 32'(stallD), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkStages($sformatf("mstall%0d", i), 18'h11, 1, 18'h22, 1, '0, 0);
            checkVal($sformatf("mstall%0d stallD", i), 32'(stallD), 1);
        end
        mem_stall = 0;
        #1 checkVal("mem_stall released stallD", 32'(stallD), 0);
        tick();
        checkStages("resume1", 18'h33, 1, 18'h11, 1, 18'h22, 1);
        setD('0, 0);
        tick();
        checkStages("resume2", '0, 0, 18'h33, 1, 18'h11, 1);
        tick(); tick();

        // ---- divide, DIV_LAT=4: 5 busy cycles then one DONE ----
        setD(18'h001D1, 1);
        tick();
        checkVal("div1 ctrlE loaded", 32'(ctrlE), 32'h1D1);
        div_startE = 1;
        setD(18'h000B2, 1);
        #1;
        checkVal("div1 issue busy", 32'(div_busy), 1);
        checkVal("div1 issue stallD", 32'(stallD), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal($sformatf("div1 busy%0d", i), 32'(div_busy), 1);
            checkVal($sformatf("div1 busy%0d done", i), 32'(div_done), 0);
            checkVal($sformatf("div1 busy%0d ctrlE", i), 32'(ctrlE), 32'h1D1);
            checkVal($sformatf("div1 busy%0d ctrlM", i), 32'(ctrlM), 0);
        end
        tick();
        checkVal("div1 done", 32'(div_done), 1);
        checkVal("div1 done busy", 32'(div_busy), 0);
        checkVal("div1 done stallD", 32'(stallD), 0);
        checkVal("div1 done ctrlE held", 32'(ctrlE), 32'h1D1);
        tick();
        div_startE = 0;
        setD('0, 0);
        #1;
        checkVal("div1 adv ctrlE", 32'(ctrlE), 32'h0B2);
        checkVal("div1 adv ctrlM", 32'(ctrlM), 32'h1D1);
        checkVal("div1 adv done", 32'(div_done), 0);
        checkVal("div1 adv busy", 32'(div_busy), 0);

        // ---- mem_stall while DONE: done held, no restart ----
        setD(18'h001D2, 1);
        tick();
        div_startE = 1;
        setD(18'h000C3, 1);
        for (int i = 0; i < 5; i++) tick();
        checkVal("div2 done", 32'(div_done), 1);
        mem_stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkVal($sformatf("div2 mstall%0d done", i), 32'(div_done), 1);
            checkVal($sformatf("div2 mstall%0d busy", i), 32'(div_busy), 0);
            checkVal($sformatf("div2 mstall%0d ctrlE", i), 32'(ctrlE), 32'h1D2);
        end
        mem_stall = 0;
        tick();
        div_startE = 0;
        setD('0, 0);
        #1;
        checkVal("div2 adv ctrlE", 32'(ctrlE), 32'h0C3);
        checkVal("div2 adv ctrlM", 32'(ctrlM), 32'h1D2);
        checkVal("div2 adv done", 32'(div_done), 0);

        // ---- flush_all during BUSY aborts the divide ----
        setD(18'h001D3, 1);
        tick();
        div_startE = 1;
        setD('0, 0);
        tick(); tick();
        checkVal("div3 busy before flush", 32'(div_busy), 1);
        flush_all = 1;
        tick();
        flush_all = 0;
        #1;
        checkStages("div3 flushed", '0, 0, '0, 0, '0, 0);
        checkVal("div3 busy after flush", 32'(div_busy), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkVal($sformatf("div3 no done%0d", i), 32'(div_done), 0);
            checkVal($sformatf("div3 no busy%0d", i), 32'(div_busy), 0);
        end
        div_startE = 0;

        // ---- async reset mid-stream and mid-divide ----
        setD(18'h3FFFF, 1);
        tick();
        checkVal("rst pre ctrlE", 32'(ctrlE), 32'h3FFFF);
        div_startE = 1;
        tick();
        checkVal("rst pre busy", 32'(div_busy), 1);
        #2 rst = 1'b0;
        #1;
        checkStages("async rst", '0, 0, '0, 0, '0, 0);
        checkVal("async rst busy", 32'(div_busy), 0);
        checkVal("async rst done", 32'(div_done), 0);
        tick();
        #2 rst = 1'b1;
        div_startE = 1;
        setD('0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal($sformatf("post rst busy%0d", i), 32'(div_busy), 0);
            checkVal($sformatf("post rst done%0d", i), 32'(div_done), 0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
